// File: rtl/ce_ls_expand.sv
// ce_ls_expand: widens narrow complex LS samples to the CE arithmetic width
// (sign-extend, then x2^divide_width), re-frames packets against fftpts_in and
// reports framing errors. Output register plus a 1-entry skid buffer give full
// ready/valid backpressure with a registered sink_ready.
module ce_ls_expand #(
   parameter int wDataIn      = 16,
   parameter int wDataOut     = 36,
   parameter int divide_width = 16
) (
   input  logic                clk,
   input  logic                rst_sync,
   input  logic                sink_valid,
   output logic                sink_ready,
   input  logic [1:0]          sink_error,
   input  logic                sink_sop,
   input  logic                sink_eop,
   input  logic [wDataIn-1:0]  sink_real,
   input  logic [wDataIn-1:0]  sink_imag,
   input  logic [11:0]         fftpts_in,
   output logic                source_valid,
   input  logic                source_ready,
   output logic [1:0]          source_error,
   output logic                source_sop,
   output logic                source_eop,
   output logic [wDataOut-1:0] source_real,
   output logic [wDataOut-1:0] source_imag,
   output logic [11:0]         fftpts_out
);

   // beat layout: {sop, eop, error[1:0], fftpts[11:0], real, imag}
   localparam int BW = 2 * wDataOut + 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_IN_PKT = 2'd1,
      S_DROP   = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [12:0]   r_cnt, w_cnt_nxt;
   logic [12:0]   r_len, w_len_nxt, w_len_in;
   logic [11:0]   r_fft, w_fft_nxt;
   logic          w_emit, w_sop, w_eop;
   logic [1:0]    w_err;
   logic          r_sink_ready, w_acc;
   logic          r_out_valid, r_skid_full;
   logic          w_skid_load, w_skid_unload, w_skid_full_nxt;
   logic [BW-1:0] r_out_beat, r_skid_beat, w_new_beat;

   // sign-extend to the wide width, then shift into the upper bits
   function automatic logic [wDataOut-1:0] f_scale(input logic [wDataIn-1:0] x);
      logic signed [wDataOut-1:0] v_ext;
      v_ext = wDataOut'($signed(x));
      return v_ext <<< divide_width;
   endfunction

   assign w_acc    = sink_valid & r_sink_ready;
   assign w_len_in = (fftpts_in == 12'd0) ? 13'd4096 : {1'b0, fftpts_in};

   // framing FSM: classify each accepted beat as emitted or dropped, set sop/eop/error
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_fft_nxt   = r_fft;
      w_emit      = 1'b0;
      w_sop       = 1'b0;
      w_eop       = 1'b0;
      w_err       = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (w_acc && sink_sop) begin
               w_emit    = 1'b1;
               w_sop     = 1'b1;
               w_cnt_nxt = 13'd1;
               w_len_nxt = w_len_in;
               w_fft_nxt = fftpts_in;
               if (w_len_in == 13'd1) begin
                  w_eop = 1'b1;
                  if (sink_eop) begin
                     w_err       = sink_error;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_err       = 2'b10;
                     w_state_nxt = S_DROP;
                  end
               end else if (sink_eop) begin
                  w_eop       = 1'b1;
                  w_err       = 2'b01;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_err       = sink_error;
                  w_state_nxt = S_IN_PKT;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_IN_PKT: begin
            if (w_acc) begin
               w_emit    = 1'b1;
               w_cnt_nxt = r_cnt + 13'd1;
               if (w_cnt_nxt == r_len) begin
                  w_eop = 1'b1;
                  if (sink_eop) begin
                     w_err       = sink_sop ? 2'b11 : sink_error;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_err       = 2'b10;
                     w_state_nxt = S_DROP;
                  end
               end else if (sink_eop) begin
                  w_eop       = 1'b1;
                  w_err       = 2'b01;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_err       = sink_sop ? 2'b11 : sink_error;
                  w_state_nxt = S_IN_PKT;
               end
            end else begin
               w_state_nxt = S_IN_PKT;
            end
         end
         S_DROP: begin
            if (w_acc && sink_eop) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DROP;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_new_beat = {w_sop, w_eop, w_err, w_fft_nxt, f_scale(sink_real), f_scale(sink_imag)};

   // skid fills only when a new beat arrives while the output is stalled;
   // it can never be loaded while full because sink_ready is then low
   assign w_skid_load     = w_acc & w_emit & r_out_valid & ~source_ready;
   assign w_skid_unload   = r_out_valid & source_ready & r_skid_full;
   assign w_skid_full_nxt = w_skid_load | (r_skid_full & ~w_skid_unload);

   // FSM state, packet length and beat counter registers
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         r_state <= S_IDLE;
         r_cnt   <= 13'd0;
         r_len   <= 13'd0;
         r_fft   <= 12'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_len   <= w_len_nxt;
         r_fft   <= w_fft_nxt;
      end
   end

   // output register, skid buffer and registered sink_ready
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         r_out_valid  <= 1'b0;
         r_out_beat   <= '0;
         r_skid_full  <= 1'b0;
         r_skid_beat  <= '0;
         r_sink_ready <= 1'b0;
      end else begin
         if (w_skid_load) begin
            r_skid_full <= 1'b1;
            r_skid_beat <= w_new_beat;
         end else if (w_acc && w_emit) begin
            r_out_valid <= 1'b1;
            r_out_beat  <= w_new_beat;
         end else if (r_out_valid && source_ready) begin
            if (r_skid_full) begin
               r_out_beat  <= r_skid_beat;
               r_skid_full <= 1'b0;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else begin
            r_out_valid <= r_out_valid;
         end
         r_sink_ready <= ~w_skid_full_nxt;
      end
   end

   assign sink_ready   = r_sink_ready;
   assign source_valid = r_out_valid;
   assign {source_sop, source_eop, source_error, fftpts_out, source_real, source_imag} = r_out_beat;

endmodule

// File: doc/ce_ls_expand.md
Name: ce_ls_expand

Overview:
- Inverse-direction companion to the CE LS down-scaler.
- Accepts narrow complex samples on an Avalon-ST style sink with full ready/valid backpressure.
- Sign-extends each sample and scales it up by 2^divide_width to the wide CE arithmetic width.
- Re-frames packets against fftpts_in, regenerating sop/eop and flagging length/framing errors; sits between the 16-bit LS estimate stream and the 36-bit interpolation/equalisation datapath.

Parameters:
- wDataIn, 16: sink sample width per component (two's complement).
- wDataOut, 36: source sample width per component; must be >= wDataIn+divide_width.
- divide_width, 16: left-shift amount, i.e. x65536, the inverse of the LS /65536 scaling.

Ports:
- clk  in  1  clock.
- rst_sync  in  1  synchronous reset, active high.
- sink_valid  in  1  input beat valid.
- sink_ready  out  1  block can accept a beat.
- sink_error  in  2  upstream error code per beat.
- sink_sop  in  1  first beat of packet.
- sink_eop  in  1  last beat of packet.
- sink_real  in  wDataIn  real component.
- sink_imag  in  wDataIn  imaginary component.
- fftpts_in  in  12  expected packet length, sampled on the sop beat.
- source_valid  out  1  output beat valid.
- source_ready  in  1  downstream accepts a beat.
- source_error  out  2  per-beat error: 00 ok, 01 short packet, 10 long packet, 11 sop inside packet.
- source_sop  out  1  first output beat.
- source_eop  out  1  last output beat.
- source_real  out  wDataOut  scaled real component.
- source_imag  out  wDataOut  scaled imaginary component.
- fftpts_out  out  12  registered length of the current output packet.

Behaviour:
- Reset (rst_sync=1 at a clk edge): all outputs 0, including sink_ready.
  - FSM goes to IDLE; counters and skid buffer are cleared; any in-flight beats are discarded.
  - sink_ready rises the first cycle after rst_sync deasserts.
- Handshake:
  - A sink beat transfers when sink_valid&&sink_ready; a source beat transfers when source_valid&&source_ready.
  - Data path is an output register plus a 1-entry skid buffer. sink_ready is a register equal to !skid_full, so there is no combinational path from source_ready to sink_ready.
  - Latency is 1 cycle from sink transfer to source_valid when unstalled; throughput is 1 beat/cycle under continuous source_ready.
  - Source outputs are held stable while source_valid&&!source_ready.
- Arithmetic: out = {sign-extend(in), divide_width zeros}, i.e. in*2^divide_width. No rounding or saturation is possible. Real and imag are handled identically.
- Length: len = fftpts_in sampled on an accepted sop beat; len==0 means 4096. A 13-bit beat counter cnt counts accepted in-packet beats.
- FSM:
  - IDLE: accepted beats without sop are consumed and dropped (no output).
    - Beat with sop: emit with source_sop=1, cnt=1, fftpts_out=fftpts_in, then go to IN_PKT.
    - If len==1: the same beat also gets source_eop=1, and the FSM stays in IDLE or goes to DROP per the rules below.
  - IN_PKT: each accepted beat is emitted and cnt increments.
    - sink_eop with cnt<len: emit source_eop=1, error 01, go to IDLE.
    - cnt reaches len with sink_eop=1: emit source_eop=1, error 00 (or forwarded sink_error), go to IDLE.
    - cnt reaches len with sink_eop=0: emit source_eop=1, error 10, go to DROP.
    - sink_sop mid-packet: emit the beat with source_sop=0 and error 11; counting continues.
  - DROP: beats are consumed without output until an accepted beat has sink_eop=1, then go to IDLE.
    - A sop in DROP is dropped; the packet does not restart.
- Error priority per beat: framing error (01/10/11) > forwarded sink_error > 00. Where two framing errors coincide on one beat, 11 loses to 01/10.
- Simultaneous sop and eop in IDLE with len!=1: short-packet error 01 on that single beat.
- Dropped beats never assert source_valid and never stall: sink_ready is still governed only by the skid state.

Test Plan:
- Reset, then fftpts_in=4, beats 0x0001, 0xFFFF, 0x7FFF, 0x8000 with sop/eop correct and source_ready=1.
  - Output is 0x0_0001_0000, 0xF_FFFF_0000, 0x0_7FFF_0000, 0xF_8000_0000.
  - sop on beat 1, eop on beat 4, error 00, latency 1 cycle, fftpts_out=4.
- Backpressure: 8-beat packet with source_ready toggling 1,0,0,1 repeatedly.
  - All 8 beats arrive in order with none lost or duplicated.
  - sink_ready drops only while the skid is full; outputs are stable during stalls.
- Short packet: fftpts_in=8, sink_eop on beat 5 -> 5 beats out, beat 5 has eop=1, error=01; FSM returns to IDLE.
- Long packet: fftpts_in=4, 6 beats with eop on beat 6.
  - Output is 4 beats, beat 4 has eop=1 and error=10; beats 5-6 are dropped.
  - The next sop packet is emitted normally.
- Stray data and mid-packet sop:
  - 3 beats without sop in IDLE are dropped.
  - Then a 4-beat packet with sop re-asserted on beat 3 -> beat 3 out with sop=0, error=11, and eop still on beat 4.
- Reset mid-packet: assert rst_sync after beat 2 of 8.
  - All outputs read 0 the next cycle; the following packet starts cleanly with cnt=1 and correct sop/eop.
